eq_sweep_driver: RTL and testbench

EQ_SWEEP_DRIVER -- requirements
Module: eq_sweep_driver

---
 rtl/eq_sweep_driver_if.sv | 24 ++
 rtl/eq_sweep_driver.sv | 101 ++++++++++
 tb/tb_eq_sweep_driver.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/eq_sweep_driver_if.sv
// Operand/handshake bundle between the sweep driver (master) and the
// comparator-under-test plus its controller (slave).
interface eq_sweep_driver_if;
    logic       start;
    logic       abort;
    logic       res;
    logic [3:0] a;
    logic [3:0] b;
    logic       set;
    logic       busy;
    logic       done;
    logic [8:0] match_cnt;
    logic [8:0] err_cnt;

    modport master (
        input  start, abort, res,
        output a, b, set, busy, done, match_cnt, err_cnt
    );

    modport slave (
        output start, abort, res,
        input  a, b, set, busy, done, match_cnt, err_cnt
    );
endinterface

// File: rtl/eq_sweep_driver.sv
// Exhaustive 4-bit equality-comparator sweep: drives all 256 {a,b} pairs and
// tallies matches/errors. Define EQ_SWEEP_STOP_ON_ERR_EN to halt on first error.
module eq_sweep_driver #(
    parameter int RES_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    eq_sweep_driver_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRIVE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0] LAT_M1 = 4'(RES_LAT - 1);

    logic [2:0] state;
    logic       armed;
    logic [7:0] idx;
    logic [3:0] wait_cnt;
    logic [8:0] match_cnt;
    logic [8:0] err_cnt;
    logic       pair_err;

    assign pair_err = (bus.res != (idx[7:4] == idx[3:0]));

    // start clears and arms in the same cycle; the sweep launches one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            armed     <= 1'b0;
            idx       <= 8'd0;
            wait_cnt  <= 4'd0;
            match_cnt <= 9'd0;
            err_cnt   <= 9'd0;
        end else if (bus.abort) begin
            state <= S_IDLE;
            armed <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (armed) begin
                        armed <= 1'b0;
                        state <= S_DRIVE;
                    end else if (bus.start) begin
                        idx       <= 8'd0;
                        match_cnt <= 9'd0;
                        err_cnt   <= 9'd0;
                        armed     <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_DRIVE: begin
                    wait_cnt <= LAT_M1;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_CHECK: begin
                    if (bus.res) begin
                        match_cnt <= match_cnt + 9'd1;
                    end
                    if (pair_err) begin
                        err_cnt <= err_cnt + 9'd1;
                    end
`ifdef EQ_SWEEP_STOP_ON_ERR_EN
                    // failing pair stays on a/b for inspection
                    if (pair_err) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= (idx == 8'hFF) ? S_DONE : S_DRIVE;
                    end
`else
                    idx   <= idx + 8'd1;
                    state <= (idx == 8'hFF) ? S_DONE : S_DRIVE;
`endif
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.a         = idx[7:4];
    assign bus.b         = idx[3:0];
    assign bus.set       = (state == S_DRIVE);
    assign bus.busy      = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CHECK);
    assign bus.done      = (state == S_DONE);
    assign bus.match_cnt = match_cnt;
    assign bus.err_cnt   = err_cnt;

endmodule

// File: tb/tb_eq_sweep_driver.sv
// Bench for eq_sweep_driver: two instances (RES_LAT=1 and 3) driven by a
// table-based comparator whose expected sweep outcome is computed pair by pair.
module tb_eq_sweep_driver;

    logic clk;
    logic rst_n;
    logic start_drv;
    logic abort_drv;
    int   sel;
    int   checks;
    int   failures;
    bit   stop_en;
    logic tbl [0:255];

    eq_sweep_driver_if bus1 ();
    eq_sweep_driver_if bus3 ();

    eq_sweep_driver #(.RES_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    eq_sweep_driver #(.RES_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    assign bus1.start = start_drv && (sel == 0);
    assign bus1.abort = abort_drv && (sel == 0);
    assign bus3.start = start_drv && (sel == 1);
    assign bus3.abort = abort_drv && (sel == 1);
    assign bus1.res   = tbl[{bus1.a, bus1.b}];
    assign bus3.res   = tbl[{bus3.a, bus3.b}];

    logic [3:0] o_a, o_b;
    logic       o_set, o_busy, o_done;
    logic [8:0] o_m, o_e;
    assign o_a    = (sel == 1) ? bus3.a         : bus1.a;
    assign o_b    = (sel == 1) ? bus3.b         : bus1.b;
    assign o_set  = (sel == 1) ? bus3.set       : bus1.set;
    assign o_busy = (sel == 1) ? bus3.busy      : bus1.busy;
    assign o_done = (sel == 1) ? bus3.done      : bus1.done;
    assign o_m    = (sel == 1) ? bus3.match_cnt : bus1.match_cnt;
    assign o_e    = (sel == 1) ? bus3.err_cnt   : bus1.err_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0 ideal, 1 stuck-0, 2 stuck-1, 3 ideal with random flips, 4 fully random
    task automatic fill(input int mode);
        for (int i = 0; i < 256; i++) begin
            logic eq;
            eq = (i[7:4] == i[3:0]);
            case (mode)
                0: tbl[i] = eq;
                1: tbl[i] = 1'b0;
                2: tbl[i] = 1'b1;
                3: tbl[i] = ($urandom_range(0, 31) == 0) ? ~eq : eq;
                default: tbl[i] = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic sweep(input string tag, input int lat);
        int exp_m, exp_e, exp_n, exp_idx, exp_lat, n, sets;
        logic [8:0] m_hold;
        exp_m = 0; exp_e = 0; exp_n = 0; exp_idx = 0;
        for (int i = 0; i < 256; i++) begin
            logic eq;
            eq = (i[7:4] == i[3:0]);
            exp_n++;
            if (tbl[i]) exp_m++;
            if (tbl[i] != eq) begin
                exp_e++;
                if (stop_en) begin
                    exp_idx = i;
                    break;
                end
            end
        end
        exp_lat = 1 + exp_n * (2 + lat);

        @(negedge clk);
        start_drv = 1'b1;
        @(posedge clk);
        #1 start_drv = 1'b0;
        n = 0;
        sets = 0;
        while (n < exp_lat + 20) begin
            @(posedge clk);
            n++;
            #1;
            if (o_set) sets++;
            // a start pulse mid-sweep must not restart anything
            start_drv = (n == 20 && exp_lat > 40);
            if (o_done) break;
        end
        start_drv = 1'b0;
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_match"}, o_m, exp_m);
        check({tag, "_err"}, o_e, exp_e);
        check({tag, "_ab"}, {o_a, o_b}, exp_idx);
        check({tag, "_sets"}, sets, exp_n);
        m_hold = o_m;
        repeat (5) @(posedge clk);
        #1;
        check({tag, "_done_hold"}, {o_done, o_m}, {1'b1, m_hold});
    endtask

    initial begin
        logic [8:0] m_cap, e_cap;
        checks = 0;
        failures = 0;
`ifdef EQ_SWEEP_STOP_ON_ERR_EN
        stop_en = 1'b1;
`else
        stop_en = 1'b0;
`endif
        rst_n = 1'b0;
        start_drv = 1'b0;
        abort_drv = 1'b0;
        sel = 0;
        fill(0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_dut1", {bus1.a, bus1.b, bus1.set, bus1.busy, bus1.done, bus1.match_cnt, bus1.err_cnt}, 0);
        check("reset_dut3", {bus3.a, bus3.b, bus3.set, bus3.busy, bus3.done, bus3.match_cnt, bus3.err_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_after_reset", {o_busy, o_done, o_set}, 0);

        fill(0); sweep("ideal_l1", 1);
        fill(1); sweep("stuck0", 1);
        fill(2); sweep("stuck1", 1);
        fill(3); sweep("flips", 1);
        fill(4); sweep("random", 1);
        sel = 1;
        fill(3); sweep("flips_l3", 3);

        // abort at cycle 100 of an ideal RES_LAT=3 sweep
        fill(0);
        @(negedge clk);
        start_drv = 1'b1;
        @(posedge clk);
        #1 start_drv = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        check("busy_before_abort", o_busy, 1);
        abort_drv = 1'b1;
        m_cap = o_m;
        e_cap = o_e;
        @(posedge clk);
        #1 abort_drv = 1'b0;
        check("abort_idle", {o_set, o_busy, o_done}, 0);
        check("abort_counts_kept", {o_m, o_e}, {m_cap, e_cap});
        repeat (3) @(posedge clk);
        #1;
        check("abort_stays_idle", o_busy, 0);
        sweep("abort_restart", 3);

        // asynchronous reset at cycle 300 of a RES_LAT=1 sweep
        sel = 0;
        @(negedge clk);
        start_drv = 1'b1;
        @(posedge clk);
        #1 start_drv = 1'b0;
        repeat (299) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_dut1", {bus1.a, bus1.b, bus1.set, bus1.busy, bus1.done, bus1.match_cnt, bus1.err_cnt}, 0);
        check("async_rst_dut3", {bus3.match_cnt, bus3.err_cnt, bus3.done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_midrst", {o_busy, o_done}, 0);
        sweep("post_reset", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
